// File: rtl/xyz_rectify_pkg.sv
// Shared types and helpers for the rectification phase datapath.
// Edge behaviour of the fetch block is selected by XYZ_RECTIFY_EDGE_CLAMP_EN.
package xyz_rectify_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        SERVE = 1'b1
    } fetch_state_t;

    // Wrapped phase is a PHASE_DW-bit word; full scale corresponds to 2*pi.
    localparam int PHASE_DW_NOM = 15;
    localparam int PI           = 1 << (PHASE_DW_NOM - 1);
    localparam int PI2          = 1 << PHASE_DW_NOM;

    function automatic logic [31:0] coord_index(input logic [31:0] c, input int fbit);
        return c >> fbit;
    endfunction

    function automatic logic [31:0] coord_frac(input logic [31:0] c, input int fbit);
        return c & ((32'd1 << fbit) - 32'd1);
    endfunction

endpackage

// File: rtl/xyz_rectify_line_ram.sv
// One-line phase buffer: one write port, two synchronous read ports sharing a read enable.
module xyz_rectify_line_ram
    import xyz_rectify_pkg::*;
#(
    parameter  int LINE_W   = 1024,
    parameter  int PHASE_DW = 15,
    localparam int AW       = $clog2(LINE_W)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [PHASE_DW-1:0] wdata,
    input  logic                re,
    input  logic [AW-1:0]       raddr_a,
    input  logic [AW-1:0]       raddr_b,
    output logic [PHASE_DW-1:0] rdata_a,
    output logic [PHASE_DW-1:0] rdata_b
);

    logic [PHASE_DW-1:0] mem [LINE_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/xyz_rectify_phase_fetch.sv
// Buffers one line of wrapped phase, then serves adjacent-pair fetches to the interpolator.
// Out-of-range requests are clamped to the last pixel when XYZ_RECTIFY_EDGE_CLAMP_EN is defined, else dropped.
module xyz_rectify_phase_fetch
    import xyz_rectify_pkg::*;
#(
    parameter int FBIT     = 8,
    parameter int PHASE_DW = 15,
    parameter int PASS_DW  = 8,
    parameter int LINE_W   = 1024,
    parameter int XW       = $clog2(LINE_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PHASE_DW-1:0] pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic                pix_last,
    input  logic [XW+FBIT-1:0]  coord,
    input  logic [PASS_DW-1:0]  coord_pass_data,
    input  logic                coord_valid,
    output logic                coord_ready,
    input  logic                coord_last,
    output logic [PHASE_DW-1:0] phase1,
    output logic [PHASE_DW-1:0] phase2,
    output logic [FBIT-1:0]     phase_frac,
    output logic [PASS_DW-1:0]  phase_pass_data,
    output logic                phase_valid,
    input  logic                phase_ready,
    output logic                oor_err
);

    localparam int LW = XW + 1;
    localparam logic [XW-1:0] LAST_PTR = XW'(LINE_W - 1);

    fetch_state_t        state, state_nxt;
    logic [XW-1:0]       wr_ptr;
    logic [LW-1:0]       len;
    logic                en, pix_acc, coord_acc, fill_done, fill_ovf, oor_drop;
    logic [XW-1:0]       x_p0, last_x_p0, ra_p0, rb_p0;
    logic [FBIT-1:0]     f_p0, frac_sel_p0;
    logic                in_range_p0, vld_p0;
    logic                vld_p1;
    logic [FBIT-1:0]     frac_p1;
    logic [PASS_DW-1:0]  pass_p1;
    logic [PHASE_DW-1:0] rdata_a, rdata_b;

    assign en        = !phase_valid || phase_ready;
    assign pix_acc   = pix_valid && pix_ready;
    assign coord_acc = coord_valid && coord_ready;
    assign fill_done = pix_last || (wr_ptr == LAST_PTR);
    assign fill_ovf  = !pix_last && (wr_ptr == LAST_PTR);

    always_comb begin
        state_nxt   = state;
        pix_ready   = 1'b0;
        coord_ready = 1'b0;
        case (state)
            FILL: begin
                pix_ready = 1'b1;
                if (pix_valid && fill_done) state_nxt = SERVE;
            end
            SERVE: begin
                coord_ready = en;
                if (coord_valid && en && coord_last) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Stage 0: request decode and read-address selection
    assign x_p0        = XW'(coord_index(32'(coord), FBIT));
    assign f_p0        = FBIT'(coord_frac(32'(coord), FBIT));
    assign last_x_p0   = XW'(len - LW'(1));
    assign in_range_p0 = (LW'(x_p0) + LW'(1)) < len;

`ifdef XYZ_RECTIFY_EDGE_CLAMP_EN
    assign vld_p0      = coord_acc;
    assign oor_drop    = 1'b0;
    assign ra_p0       = in_range_p0 ? x_p0 : last_x_p0;
    assign rb_p0       = in_range_p0 ? XW'(x_p0 + XW'(1)) : last_x_p0;
    assign frac_sel_p0 = in_range_p0 ? f_p0 : '0;
`else
    assign vld_p0      = coord_acc && in_range_p0;
    assign oor_drop    = coord_acc && !in_range_p0;
    assign ra_p0       = x_p0;
    assign rb_p0       = XW'(x_p0 + XW'(1));
    assign frac_sel_p0 = f_p0;
`endif

    xyz_rectify_line_ram #(
        .LINE_W   (LINE_W),
        .PHASE_DW (PHASE_DW)
    ) u_line_ram (
        .clk     (clk),
        .we      (pix_acc),
        .waddr   (wr_ptr),
        .wdata   (pix_data),
        .re      (en),
        .raddr_a (ra_p0),
        .raddr_b (rb_p0),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            wr_ptr      <= '0;
            len         <= '0;
            oor_err     <= 1'b0;
            vld_p1      <= 1'b0;
            phase_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pix_acc) begin
                if (fill_done) begin
                    wr_ptr <= '0;
                    len    <= LW'(wr_ptr) + LW'(1);
                end else begin
                    wr_ptr <= wr_ptr + XW'(1);
                end
            end
            if ((pix_acc && fill_ovf) || oor_drop) oor_err <= 1'b1;
            if (en) begin
                vld_p1      <= vld_p0;
                phase_valid <= vld_p1;
            end
        end
    end

    // Stage 1: sideband aligned with the synchronous RAM read
    always_ff @(posedge clk) begin
        if (en) begin
            frac_p1 <= frac_sel_p0;
            pass_p1 <= coord_pass_data;
        end
    end

    // Stage 2: output register, held while the interpolator stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase1          <= '0;
            phase2          <= '0;
            phase_frac      <= '0;
            phase_pass_data <= '0;
        end else if (en && vld_p1) begin
            phase1          <= rdata_a;
            phase2          <= rdata_b;
            phase_frac      <= frac_p1;
            phase_pass_data <= pass_p1;
        end
    end

endmodule

// File: doc/xyz_rectify_phase_fetch.md
# xyz_rectify_phase_fetch

Upstream feeder for `xyz_rectify_phase_interp`. It buffers one line of wrapped phase pixels, then serves rectification coordinate requests. Each request carries an integer pixel index plus a FBIT-bit fraction. For each request the block emits the adjacent phase pair and the fraction on the interpolator's `phase_*` valid/ready input. A sideband pass word travels with each request and is not modified.

## Interface
Parameters:
- FBIT, 8, fraction bits of the coordinate
- PHASE_DW, 15, phase sample width
- PASS_DW, 8, sideband pass-through width
- LINE_W, 1024, maximum line length in pixels
- XW, $clog2(LINE_W), integer index width (derived)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- pix_data  in  PHASE_DW  input phase pixel
- pix_valid / pix_ready  in / out  1  pixel handshake
- pix_last  in  1  last pixel of the line
- coord  in  XW+FBIT  {index[XW-1:0], frac[FBIT-1:0]}
- coord_pass_data  in  PASS_DW  sideband word for the request
- coord_valid / coord_ready  in / out  1  request handshake
- coord_last  in  1  last request for the current line
- phase1, phase2  out  PHASE_DW  samples line[x], line[x+1]
- phase_frac  out  FBIT  fraction
- phase_pass_data  out  PASS_DW  sideband word, delayed to match the output
- phase_valid / phase_ready  out / in  1  output handshake
- oor_err  out  1  sticky error flag

## Operation
- FSM states: FILL, SERVE. Reset state is FILL.
- FILL:
  - pix_ready=1, coord_ready=0.
  - Each accepted pixel is written at wr_ptr, then wr_ptr increments.
  - Transition to SERVE when the accepted beat has pix_last=1 or wr_ptr==LINE_W-1. Latch len=wr_ptr+1 and reset wr_ptr to 0.
  - Reaching LINE_W-1 without pix_last sets oor_err. A pix_last that arrives later is treated as belonging to the next line.
- SERVE:
  - pix_ready=0.
  - Pipeline enable: en = !phase_valid || phase_ready. coord_ready = en.
  - On an accepted request: x = coord[XW+FBIT-1:FBIT], f = coord[FBIT-1:0].
  - In range (x+1 < len): read addresses x and x+1; output frac = f.
  - Out of range (x >= len-1): behaviour is set by the macro (see Configuration).
  - An accepted beat with coord_last=1 returns the FSM to FILL on the next cycle. Reads are already captured, so the in-flight pipeline drains independently of the FSM.
- Line storage is a 1-write, 2-synchronous-read RAM. Reads are enabled only when en=1, so stage 1 holds its data while the pipeline is stalled.
- No arithmetic is performed on phase values. Wrap handling belongs to the interpolator.
- oor_err is cleared only by reset.

## Timing
- Reset values: pix_ready=1, coord_ready=0, phase_valid=0, phase1=phase2=0, phase_frac=0, phase_pass_data=0, oor_err=0, wr_ptr=0, len=0.
- Latency: a request accepted in cycle n produces phase_valid=1 in cycle n+2.
- Throughput: 1 request per cycle while phase_ready=1.
- Output handshake: phase_* stay stable while phase_valid && !phase_ready. phase_valid never drops without a handshake.
- FILL→SERVE: the cycle after the final pixel is accepted, coord_ready may already be 1.
- SERVE→FILL: pix_ready=1 the cycle after coord_last is accepted, even if outputs are still pending.
- Single-pixel line (pix_last on the first beat): len=1, so every request is out of range.
- Reset asserted mid-operation: on the next edge, buffer contents and in-flight outputs are discarded, phase_valid=0, and the FSM is in FILL.

## Configuration
`XYZ_RECTIFY_EDGE_CLAMP_EN` selects out-of-range handling:
- Defined: out-of-range requests are clamped. phase1=phase2=line[len-1], phase_frac=0, and an output is produced. oor_err is not set.
- Undefined: out-of-range requests are accepted and dropped with no output beat, and oor_err is set.

## Structure
- Package `xyz_rectify_pkg` holds:
  - the FSM state enum;
  - a coord-field helper (index/frac split);
  - the PI / PI2 phase constants shared with the interpolator.
- Sub-module `xyz_rectify_line_ram` (parameters LINE_W, PHASE_DW): 1 write port, 2 synchronous read ports with a read enable.

## Test plan
- Basic read: fill 8 pixels with line[i]=100*i (pix_last on i=7), then request x=2, f=64. Expect phase1=200, phase2=300, phase_frac=64, phase_valid exactly 2 cycles after acceptance, and pass data echoed.
- Backpressure: stream 4 requests while phase_ready is held low for 5 cycles. Expect coord_ready=0 while stalled, all 4 outputs delivered in order, and none lost or duplicated.
- Edge, len=8, request x=7 f=128 then x=9:
  - with EN defined: two outputs, each phase1=phase2=700, frac=0;
  - without EN: no outputs, oor_err=1.
- Line turnaround: accept coord_last, then expect pix_ready=1 on the next cycle. A second line with line[i]=50+i, then request x=0 f=1, gives phase1=50, phase2=51.
- Overflow: send LINE_W pixels with no pix_last. Expect SERVE entered, len=LINE_W, oor_err=1.
- Reset while phase_valid=1 and stalled: expect phase_valid=0, pix_ready=1, coord_ready=0 the cycle after rst_n is sampled low.
